// File: rtl/xpb_pkg.sv
// Shared xpb LUT scheduler defaults, accumulator width derivation and FSM state encoding.
// No timing or flow control of its own; consumed by xpb_lut_sched and its testbench.
package xpb_pkg;

    localparam int XPB_NUM_SEG = 8;
    localparam int XPB_SEG_W   = 5;
    localparam int XPB_WORD_W  = 1024;

    // Keeps the segment counter at least one bit wide for a single-segment build.
    function automatic int xpb_cnt_w(input int num_seg);
        return (num_seg > 1) ? $clog2(num_seg) : 1;
    endfunction

    // Sum of num_seg words never exceeds word_w + clog2(num_seg) bits; one spare bit on top.
    function automatic int xpb_acc_w(input int word_w, input int num_seg);
        return word_w + $clog2(num_seg) + 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } xpb_state_e;

endpackage

// File: rtl/xpb_acc.sv
// Clearable accumulator register, result visible one cycle after clr/en.
// No backpressure: clr wins over en, state holds when both are low.
module xpb_acc #(
    parameter int ACC_W = 1028
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [ACC_W-1:0] add,
    output logic [ACC_W-1:0] sum
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum <= '0;
        end else if (clr) begin
            sum <= '0;
        end else if (en) begin
            sum <= sum + add;
        end
    end

endmodule

// File: rtl/xpb_lut_sched.sv
// Walks NUM_SEG xpb tables one segment per cycle and sums the looked-up words; latency NUM_SEG+1 (NUM_SEG+2 with XPB_LUT_REG_EN).
// One operand in flight: in_ready only in IDLE, result held in DONE until out_ready.
module xpb_lut_sched
    import xpb_pkg::*;
#(
    parameter int  NUM_SEG = XPB_NUM_SEG,
    parameter int  SEG_W   = XPB_SEG_W,
    parameter int  WORD_W  = XPB_WORD_W,
    localparam int CNT_W   = xpb_cnt_w(NUM_SEG),
    localparam int ACC_W   = xpb_acc_w(WORD_W, NUM_SEG)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_SEG*SEG_W-1:0] in_idx,
    output logic [CNT_W-1:0]         lut_seg,
    output logic [SEG_W-1:0]         lut_idx,
    input  logic [WORD_W-1:0]        lut_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         out_sum
);

    localparam logic [CNT_W-1:0] LAST_SEG = CNT_W'(NUM_SEG - 1);

    xpb_state_e       state_q;
    xpb_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [SEG_W-1:0] seg_q [NUM_SEG];
    logic             accept;
    logic             run;
    logic             acc_en;
    logic [ACC_W-1:0] acc_add;

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        run       = 1'b0;
        lut_seg   = '0;
        lut_idx   = '0;
        case (state_q)
            IDLE: begin
                in_ready = !reset;
                if (in_valid && !reset) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                run     = 1'b1;
                lut_seg = cnt_q;
                lut_idx = seg_q[cnt_q];
                if (cnt_q == LAST_SEG) begin
`ifdef XPB_LUT_REG_EN
                    state_d = DRAIN;
`else
                    state_d = DONE;
`endif
                end
            end
            DRAIN: state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= (cnt_q == LAST_SEG) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Operand is snapshotted so the producer may change in_idx once accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_SEG; k++) begin
                seg_q[k] <= '0;
            end
        end else if (accept) begin
            for (int k = 0; k < NUM_SEG; k++) begin
                seg_q[k] <= in_idx[k*SEG_W +: SEG_W];
            end
        end
    end

`ifdef XPB_LUT_REG_EN
    logic [WORD_W-1:0] data_q;
    logic              data_vld;

    // Table output is retimed one stage; data_vld marks which registered words belong to this operand.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q   <= '0;
            data_vld <= 1'b0;
        end else begin
            data_q   <= lut_data;
            data_vld <= run;
        end
    end

    assign acc_en  = data_vld;
    assign acc_add = {{(ACC_W-WORD_W){1'b0}}, data_q};
`else
    assign acc_en  = run;
    assign acc_add = {{(ACC_W-WORD_W){1'b0}}, lut_data};
`endif

    xpb_acc #(
        .ACC_W (ACC_W)
    ) u_acc (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .en    (acc_en),
        .add   (acc_add),
        .sum   (out_sum)
    );

endmodule

// File: tb/tb_xpb_lut_sched.sv
// Directed bench for xpb_lut_sched with a (seg+1)*idx table model and an all-ones table mode.
// Handles both builds, with and without XPB_LUT_REG_EN.
module tb_xpb_lut_sched;

    localparam int NUM_SEG = 8;
    localparam int SEG_W   = 5;
    localparam int WORD_W  = 1024;
    localparam int ACC_W   = WORD_W + 3 + 1;
    localparam int IDX_W   = NUM_SEG * SEG_W;
`ifdef XPB_LUT_REG_EN
    localparam int EXP_LAT = NUM_SEG + 2;
`else
    localparam int EXP_LAT = NUM_SEG + 1;
`endif

    logic              clk       = 1'b0;
    logic              reset     = 1'b1;
    logic              in_valid  = 1'b0;
    logic              out_ready = 1'b1;
    logic              lut_ones  = 1'b0;
    logic [IDX_W-1:0]  in_idx    = '0;
    logic              in_ready;
    logic              out_valid;
    logic [2:0]        lut_seg;
    logic [SEG_W-1:0]  lut_idx;
    logic [WORD_W-1:0] lut_data;
    logic [ACC_W-1:0]  out_sum;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign lut_data = lut_ones ? {WORD_W{1'b1}}
                               : {{(WORD_W-9){1'b0}}, ({6'd0, lut_seg} + 9'd1) * {4'd0, lut_idx}};

    xpb_lut_sched #(
        .NUM_SEG (NUM_SEG),
        .SEG_W   (SEG_W),
        .WORD_W  (WORD_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_idx    (in_idx),
        .lut_seg   (lut_seg),
        .lut_idx   (lut_idx),
        .lut_data  (lut_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
    );

    task automatic check(input string tag, input logic [ACC_W-1:0] got, input logic [ACC_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called in the low phase of an IDLE cycle; handshake happens on the next rising edge.
    task automatic start_op(input logic [IDX_W-1:0] idx);
        in_valid = 1'b1;
        in_idx   = idx;
        check("in_ready_accept", ACC_W'(in_ready), ACC_W'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_idx   = IDX_W'({$urandom(), $urandom()});
    endtask

    task automatic wait_out(input logic [IDX_W-1:0] idx, input string tag);
        int lat;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n <= NUM_SEG) begin
                check({tag, "_lut_seg"}, ACC_W'(lut_seg), ACC_W'(n - 1));
                check({tag, "_lut_idx"}, ACC_W'(lut_idx), ACC_W'(idx[(n-1)*SEG_W +: SEG_W]));
            end
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        check({tag, "_latency"}, ACC_W'(lat), ACC_W'(EXP_LAT));
    endtask

    task automatic finish_op(input logic [ACC_W-1:0] exp, input int hold, input string tag);
        check({tag, "_sum"}, out_sum, exp);
        check({tag, "_in_ready_done"}, ACC_W'(in_ready), ACC_W'(0));
        check({tag, "_lut_seg_done"}, ACC_W'(lut_seg), ACC_W'(0));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, ACC_W'(out_valid), ACC_W'(1));
            check({tag, "_hold_sum"}, out_sum, exp);
            check({tag, "_hold_in_ready"}, ACC_W'(in_ready), ACC_W'(0));
        end
        out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_valid_drop"}, ACC_W'(out_valid), ACC_W'(0));
        check({tag, "_in_ready_idle"}, ACC_W'(in_ready), ACC_W'(1));
        check({tag, "_lut_idx_idle"}, ACC_W'(lut_idx), ACC_W'(0));
    endtask

    initial begin
        logic [IDX_W-1:0] all_1f;
        logic [IDX_W-1:0] ramp;
        logic [IDX_W-1:0] one;
        logic [ACC_W-1:0] ones_sum;
        logic             seen;

        all_1f = {IDX_W{1'b1}};
        one    = IDX_W'(1);
        ramp   = '0;
        for (int k = 0; k < NUM_SEG; k++) begin
            ramp[k*SEG_W +: SEG_W] = SEG_W'(k);
        end
        ones_sum = ACC_W'(8) * ((ACC_W'(1) << WORD_W) - ACC_W'(1));

        repeat (2) @(negedge clk);
        check("rst_in_ready", ACC_W'(in_ready), ACC_W'(0));
        check("rst_out_valid", ACC_W'(out_valid), ACC_W'(0));
        check("rst_out_sum", out_sum, ACC_W'(0));
        check("rst_lut_seg", ACC_W'(lut_seg), ACC_W'(0));
        check("rst_lut_idx", ACC_W'(lut_idx), ACC_W'(0));
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", ACC_W'(in_ready), ACC_W'(1));

        // 31 * (1+2+...+8)
        start_op(all_1f);
        wait_out(all_1f, "all1f");
        finish_op(ACC_W'(1116), 0, "all1f");

        start_op('0);
        wait_out('0, "zero");
        finish_op(ACC_W'(0), 0, "zero");

        // sum of (k+1)*k for k=0..7
        start_op(ramp);
        wait_out(ramp, "ramp");
        finish_op(ACC_W'(168), 0, "ramp");

        // Immediately follows the previous output handshake.
        start_op(all_1f);
        wait_out(all_1f, "b2b");
        finish_op(ACC_W'(1116), 0, "b2b");

        out_ready = 1'b0;
        start_op(all_1f);
        wait_out(all_1f, "hold");
        finish_op(ACC_W'(1116), 20, "hold");

        start_op(all_1f);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrun_in_ready", ACC_W'(in_ready), ACC_W'(0));
        check("midrun_out_valid", ACC_W'(out_valid), ACC_W'(0));
        check("midrun_out_sum", out_sum, ACC_W'(0));
        check("midrun_lut_seg", ACC_W'(lut_seg), ACC_W'(0));
        check("midrun_lut_idx", ACC_W'(lut_idx), ACC_W'(0));
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("midrun_no_output", ACC_W'(seen), ACC_W'(0));
        start_op(one);
        wait_out(one, "after_rst");
        finish_op(ACC_W'(1), 0, "after_rst");

        lut_ones = 1'b1;
        start_op(ramp);
        wait_out(ramp, "ones");
        finish_op(ones_sum, 0, "ones");
        lut_ones = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
